window_row_fetcher: RTL and testbench
=====================================

Name: window_row_fetcher

Overview:
- Upstream feeder for the 4x4 sliding-window stage: walks an int8 feature map stored row-major in on-chip SRAM (4 pixels per 32-bit word) and assembles one 4-row x 4-pixel block per window.
- Presents the block on four 32-bit row buses with a one-cycle start pulse, and holds the buses stable while the window stage captures rows 0..3 sequentially.
- Sequenced by the layer controller through go/busy/done.

Parameters:
- IMG_W, 32, feature-map width in pixels; multiple of 4, at least 4.
- IMG_H, 32, feature-map height in rows; at least 4.
- ROW_STRIDE, 1, vertical step between window rows; at least 1.
- ADDR_W, 10, SRAM word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle pulse; starts a full map traversal.
- base_addr  in  ADDR_W  word address of pixel (0,0); latched on accepted go.
- mem_rd_en  out  1  SRAM read strobe.
- mem_addr  out  ADDR_W  SRAM word address.
- mem_rdata  in  32  SRAM read data; valid exactly 1 cycle after mem_rd_en.
- win_ready  in  1  window stage can accept a new block.
- win_start  out  1  one-cycle pulse; row buses valid.
- A0_in, A1_in, A2_in, A3_in  out  32  window rows 0..3; pixel 0 in [31:24].
- busy  out  1  high from accepted go until done.
- done  out  1  one-cycle pulse after the last window's hold completes.

Behaviour:
- Reset: async on reset_n low, whatever the state. All outputs return to 0, FSM to IDLE, counters to 0. Restart requires a new go.
- Derived constants:
  - WPR = IMG_W/4 (words per row).
  - NCOL = WPR.
  - NROW = (IMG_H-4)/ROW_STRIDE + 1.
  - Window (r,c), r in 0..NROW-1, c in 0..NCOL-1. Order: c fastest, then r.
- Row k address: base_addr + (r*ROW_STRIDE + k)*WPR + c, computed mod 2^ADDR_W. Wrap is silent.
- FSM:
  - IDLE: go -> latch base_addr, r=c=0, busy=1, go to READ.
  - READ: 4 consecutive cycles, mem_rd_en=1, rows k=0..3. Each word is captured into row register k one cycle after its request. The last capture occurs in the first WAIT cycle.
  - WAIT: once all 4 rows are captured, go to PRESENT.
  - PRESENT: if win_ready, assert win_start for 1 cycle and go to HOLD. Otherwise stay in PRESENT with the buses stable.
  - HOLD: buses are unchanged for 4 cycles after the win_start cycle (5 cycles inclusive). Then:
    - last window -> done pulse, busy=0, go to IDLE;
    - otherwise advance c, wrapping to 0 with r+1, and go to READ.
- Latency:
  - go to first mem_rd_en: 1 cycle.
  - go to first win_start: 6 cycles, given win_ready=1.
  - Steady state: 10 cycles per window.
- A*_in change only on capture. They are never modified in PRESENT or HOLD.
- mem_addr holds its last value when mem_rd_en=0.
- go while busy: ignored, no effect.
- go in the same cycle as done: ignored; done and busy fall normally.
- win_ready dropping during HOLD: no effect.
- Parameter violations (IMG_W%4!=0, IMG_H<4, ROW_STRIDE=0) are elaboration-time assertion errors.

Optional Feature:
- Macro WINDOW_FETCH_STATS_EN.
- Defined:
  - adds output win_count (16 bits): windows issued since the last accepted go;
  - cleared on reset and on accepted go;
  - incremented on each win_start; saturates at 0xFFFF.
  - adds output stall_cycles (16 bits): count of cycles spent in PRESENT with win_ready=0; same clear and saturation rules.
- Undefined: both ports and their counters are absent. Core timing is identical.

Decomposition:
- Shared package (sys_types):
  - fetch_state_e (IDLE, READ, WAIT, PRESENT, HOLD);
  - WIN_ROWS=4, PIX_PER_WORD=4, HOLD_CYCLES=4.
- One natural sub-module, window_addr_gen. It holds the r/c/k counters and outputs mem_addr, first_window and last_window; the FSM drives its step and clear inputs.

Test Plan:
- IMG_W=8, IMG_H=4, base_addr=0x010, memory word n = {n,n,n,n}:
  - go -> addresses 0x010,0x012,0x014,0x016; then 0x011,0x013,0x015,0x017;
  - first win_start at go+6 with A0_in=0x10101010 .. A3_in=0x16161616;
  - exactly 2 win_start pulses; done 5 cycles after the second.
- win_ready held 0 for 7 cycles in PRESENT -> no win_start; A*_in stable.
  - win_start on the first cycle win_ready=1.
  - With WINDOW_FETCH_STATS_EN: stall_cycles=7.
- IMG_H=6, ROW_STRIDE=2, IMG_W=4 -> NROW=2; second window row-0 address = base+2.
- reset_n low during READ of window 1 -> all outputs 0 immediately (asynchronously, before the next edge).
  - After release, a new go restarts at (0,0) with the first address = base_addr.
- base_addr=0x3FE, ADDR_W=10, IMG_W=8 -> row-1 address wraps to 0x000, row-2 to 0x002.
- go pulsed during busy and in the done cycle -> ignored; busy stays low after done. win_count (if enabled) unchanged.

Source files
------------

// File: rtl/sys_types.sv
// Shared state encoding and window geometry constants for the window row fetcher.
package sys_types;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    PRESENT,
    HOLD
  } fetch_state_e;

  localparam int WIN_ROWS     = 4;
  localparam int PIX_PER_WORD = 4;
  localparam int HOLD_CYCLES  = 4;
  localparam int ROW_IDX_W    = $clog2(WIN_ROWS);

endpackage

// File: rtl/window_addr_gen.sv
// Window/row counters for the fetcher: walks windows column-fastest and forms the
// SRAM word address of row k of the current window (wraps silently at 2^ADDR_W).
module window_addr_gen
  import sys_types::*;
#(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ROW_STRIDE = 1,
  parameter int ADDR_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic                 step_row_i,
  input  logic                 step_win_i,
  output logic [ROW_IDX_W-1:0] row_idx_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic                 first_window_o,
  output logic                 last_window_o
);

  localparam int WPR  = IMG_W / PIX_PER_WORD;
  localparam int NCOL = WPR;
  localparam int NROW = (IMG_H - WIN_ROWS) / ROW_STRIDE + 1;
  localparam int CW   = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int RW   = (NROW > 1) ? $clog2(NROW) : 1;

  logic [ADDR_W-1:0]    base_q, base_d;
  logic [ROW_IDX_W-1:0] k_q, k_d;
  logic [CW-1:0]        c_q, c_d;
  logic [RW-1:0]        r_q, r_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0;
      k_q    <= '0;
      c_q    <= '0;
      r_q    <= '0;
    end else begin
      base_q <= base_d;
      k_q    <= k_d;
      c_q    <= c_d;
      r_q    <= r_d;
    end
  end

  // The row counter cycles through the window's rows; the column wraps into the next window row.
  always_comb begin
    base_d = base_q;
    k_d    = k_q;
    c_d    = c_q;
    r_d    = r_q;
    if (clear_i) begin
      base_d = base_addr_i;
      k_d    = '0;
      c_d    = '0;
      r_d    = '0;
    end else begin
      if (step_row_i) begin
        k_d = (k_q == ROW_IDX_W'(WIN_ROWS - 1)) ? '0 : k_q + 1'b1;
      end
      if (step_win_i) begin
        if (c_q == CW'(NCOL - 1)) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    row_idx_o      = k_q;
    addr_o         = base_q + ADDR_W'((32'(r_q) * ROW_STRIDE + 32'(k_q)) * WPR + 32'(c_q));
    first_window_o = (r_q == '0) && (c_q == '0);
    last_window_o  = (r_q == RW'(NROW - 1)) && (c_q == CW'(NCOL - 1));
  end

endmodule

// File: rtl/window_row_fetcher.sv
// Fetches 4x4 int8 blocks from row-major SRAM and presents them to the window stage.
// Optional counters win_count/stall_cycles are built when WINDOW_FETCH_STATS_EN is defined.
module window_row_fetcher
  import sys_types::*;
#(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ROW_STRIDE = 1,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              win_ready,
  output logic              win_start,
  output logic [31:0]       A0_in,
  output logic [31:0]       A1_in,
  output logic [31:0]       A2_in,
  output logic [31:0]       A3_in,
  output logic              busy,
  output logic              done
`ifdef WINDOW_FETCH_STATS_EN
  ,
  output logic [15:0]       win_count,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  if (((IMG_W % PIX_PER_WORD) != 0) || (IMG_W < PIX_PER_WORD)) begin : gBadWidth
    $error("IMG_W must be a positive multiple of %0d", PIX_PER_WORD);
  end
  if (IMG_H < WIN_ROWS) begin : gBadHeight
    $error("IMG_H must be at least %0d", WIN_ROWS);
  end
  if (ROW_STRIDE < 1) begin : gBadStride
    $error("ROW_STRIDE must be at least 1");
  end

  fetch_state_e state_q, state_d;
  logic [HOLD_W-1:0]            holdCnt_q, holdCnt_d;
  logic                         done_q;
  logic                         capValid_q;
  logic [ROW_IDX_W-1:0]         capRow_q;
  logic [WIN_ROWS-1:0][31:0]    rows_q;
  logic [ADDR_W-1:0]            addrHold_q;

  logic                         goAccept;
  logic                         holdLast;
  logic                         stepRow;
  logic                         stepWin;
  logic [ROW_IDX_W-1:0]         rowIdx;
  logic [ADDR_W-1:0]            genAddr;
  logic                         firstWindow;
  logic                         lastWindow;

  window_addr_gen #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ROW_STRIDE (ROW_STRIDE),
    .ADDR_W     (ADDR_W)
  ) uAddrGen (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear_i        (goAccept),
    .base_addr_i    (base_addr),
    .step_row_i     (stepRow),
    .step_win_i     (stepWin),
    .row_idx_o      (rowIdx),
    .addr_o         (genAddr),
    .first_window_o (firstWindow),
    .last_window_o  (lastWindow)
  );

  // A go landing in the done cycle is dropped even though the FSM is already back in IDLE.
  assign goAccept = (state_q == IDLE) && go && !done_q;
  assign holdLast = (holdCnt_q == HOLD_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      holdCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    holdCnt_d = (state_q == HOLD) ? holdCnt_q + 1'b1 : '0;
    case (state_q)
      IDLE:    if (goAccept) state_d = READ;
      READ:    if (rowIdx == ROW_IDX_W'(WIN_ROWS - 1)) state_d = WAIT;
      WAIT:    state_d = PRESENT;
      PRESENT: if (win_ready) state_d = HOLD;
      HOLD:    if (holdLast) state_d = lastWindow ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == READ);
    win_start = (state_q == PRESENT) && win_ready;
    busy      = (state_q != IDLE);
    done      = done_q;
    stepRow   = (state_q == READ);
    stepWin   = (state_q == HOLD) && holdLast && !lastWindow;
    mem_addr  = (state_q == READ) ? genAddr : addrHold_q;
  end

  // SRAM data returns one cycle after the strobe, so the row index travels with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capValid_q <= 1'b0;
      capRow_q   <= '0;
      rows_q     <= '0;
      addrHold_q <= '0;
      done_q     <= 1'b0;
    end else begin
      capValid_q <= mem_rd_en;
      capRow_q   <= rowIdx;
      if (capValid_q) begin
        rows_q[capRow_q] <= mem_rdata;
      end
      if (mem_rd_en) begin
        addrHold_q <= genAddr;
      end
      done_q <= (state_q == HOLD) && holdLast && lastWindow;
    end
  end

  assign A0_in = rows_q[0];
  assign A1_in = rows_q[1];
  assign A2_in = rows_q[2];
  assign A3_in = rows_q[3];

  firstAfterGo: assert property (@(posedge clk) disable iff (!reset_n) goAccept |=> firstWindow);

`ifdef WINDOW_FETCH_STATS_EN
  logic [15:0] winCount_q;
  logic [15:0] stallCycles_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      winCount_q    <= '0;
      stallCycles_q <= '0;
    end else if (goAccept) begin
      winCount_q    <= '0;
      stallCycles_q <= '0;
    end else begin
      if (win_start && (winCount_q != 16'hFFFF)) begin
        winCount_q <= winCount_q + 1'b1;
      end
      if ((state_q == PRESENT) && !win_ready && (stallCycles_q != 16'hFFFF)) begin
        stallCycles_q <= stallCycles_q + 1'b1;
      end
    end
  end

  assign win_count    = winCount_q;
  assign stall_cycles = stallCycles_q;
`endif

endmodule

// File: tb/tb_window_row_fetcher.sv
// Self-checking bench for window_row_fetcher: directed traversals plus randomized
// stalls/bases against a behavioural model of window order, addresses and timing.
module tb_window_row_fetcher;

  localparam int IMG_W      = 8;
  localparam int IMG_H      = 6;
  localparam int ROW_STRIDE = 2;
  localparam int ADDR_W     = 10;
  localparam int WPR        = IMG_W / 4;
  localparam int NCOL       = WPR;
  localparam int NROW       = (IMG_H - 4) / ROW_STRIDE + 1;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              go = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              win_ready = 1'b0;
  logic              win_start;
  logic [31:0]       A0_in, A1_in, A2_in, A3_in;
  logic              busy;
  logic              done;
`ifdef WINDOW_FETCH_STATS_EN
  logic [15:0]       win_count;
  logic [15:0]       stall_cycles;
`endif

  logic [31:0] mem [MEM_WORDS];
  int vectors = 0;
  int miscompares = 0;
  int winIssued;
  int stallTotal;

  window_row_fetcher #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ROW_STRIDE (ROW_STRIDE),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .go           (go),
    .base_addr    (base_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .win_ready    (win_ready),
    .win_start    (win_start),
    .A0_in        (A0_in),
    .A1_in        (A1_in),
    .A2_in        (A2_in),
    .A3_in        (A3_in),
    .busy         (busy),
`ifdef WINDOW_FETCH_STATS_EN
    .win_count    (win_count),
    .stall_cycles (stall_cycles),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  // SRAM model with one cycle of read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkRows(input string tag, input logic [31:0] expRows [4]);
    checkOutput({tag, "_A0"}, A0_in, expRows[0]);
    checkOutput({tag, "_A1"}, A1_in, expRows[1]);
    checkOutput({tag, "_A2"}, A2_in, expRows[2]);
    checkOutput({tag, "_A3"}, A3_in, expRows[3]);
  endtask

  function automatic logic [ADDR_W-1:0] rowAddr(input logic [ADDR_W-1:0] base, input int r, input int c, input int k);
    int lineNo;
    lineNo = r * ROW_STRIDE + k;
    return ADDR_W'((int'(base) + lineNo * WPR + c) % MEM_WORDS);
  endfunction

  // One full map traversal; abortWindow >= 0 pulls reset mid-READ of that window.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int firstStall,
                               input int abortWindow, input bit goInDone);
    logic [31:0]       expRows [4];
    logic [ADDR_W-1:0] a;
    int                stall;
    int                w;
    winIssued  = 0;
    stallTotal = 0;
    a          = '0;
    tick();
    go = 1'b1; base_addr = base; win_ready = 1'($urandom); #1;
    checkOutput("busy_before_go", busy, 0);
    w = 0;
    for (int r = 0; r < NROW; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        for (int k = 0; k < 4; k++) begin
          tick();
          go = 1'b0; base_addr = ADDR_W'($urandom); #1;
          a = rowAddr(base, r, c, k);
          expRows[k] = mem[a];
          checkOutput($sformatf("rd_en_w%0d_k%0d", w, k), mem_rd_en, 1);
          checkOutput($sformatf("addr_w%0d_k%0d", w, k), mem_addr, a);
          checkOutput($sformatf("busy_w%0d_k%0d", w, k), busy, 1);
          if (w == abortWindow && k == 1) begin
            #2 reset_n = 1'b0;
            #1;
            checkOutput("rst_rd_en", mem_rd_en, 0);
            checkOutput("rst_addr", mem_addr, 0);
            checkOutput("rst_win_start", win_start, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_A0", A0_in, 0);
            checkOutput("rst_A3", A3_in, 0);
            return;
          end
        end
        tick();
        win_ready = 1'($urandom); #1;
        checkOutput($sformatf("wait_rd_en_w%0d", w), mem_rd_en, 0);
        checkOutput($sformatf("wait_addr_hold_w%0d", w), mem_addr, a);
        checkOutput($sformatf("wait_win_start_w%0d", w), win_start, 0);
        stall = (w == 0 && firstStall >= 0) ? firstStall : int'($urandom_range(0, 3));
        for (int s = 0; s < stall; s++) begin
          tick();
          win_ready = 1'b0;
          go = (s == 1);
          base_addr = ADDR_W'($urandom); #1;
          checkOutput($sformatf("stall_win_start_w%0d_s%0d", w, s), win_start, 0);
          checkRows($sformatf("stall_w%0d_s%0d", w, s), expRows);
          stallTotal++;
        end
        tick();
        go = 1'b0; win_ready = 1'b1; #1;
        checkOutput($sformatf("win_start_w%0d", w), win_start, 1);
        checkRows($sformatf("present_w%0d", w), expRows);
        winIssued++;
        for (int h = 0; h < 4; h++) begin
          tick();
          win_ready = 1'($urandom);
          go = (h == 2); #1;
          checkOutput($sformatf("hold_win_start_w%0d_h%0d", w, h), win_start, 0);
          checkOutput($sformatf("hold_done_w%0d_h%0d", w, h), done, 0);
          checkOutput($sformatf("hold_busy_w%0d_h%0d", w, h), busy, 1);
          checkRows($sformatf("hold_w%0d_h%0d", w, h), expRows);
`ifdef WINDOW_FETCH_STATS_EN
          if (h == 0) checkOutput($sformatf("win_count_w%0d", w), 32'(win_count), winIssued);
`endif
        end
        w++;
      end
    end
    tick();
    go = goInDone; win_ready = 1'($urandom); #1;
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_in_done", busy, 0);
    tick();
    go = 1'b0; #1;
    checkOutput("done_cleared", done, 0);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("rd_en_after_done", mem_rd_en, 0);
`ifdef WINDOW_FETCH_STATS_EN
    checkOutput("win_count_final", 32'(win_count), winIssued);
    checkOutput("stall_cycles_final", 32'(stall_cycles), stallTotal);
`endif
    tick();
    #1;
    checkOutput("idle_rd_en", mem_rd_en, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  initial begin
    for (int n = 0; n < MEM_WORDS; n++) mem[n] = {4{n[7:0]}};
    reset_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rd_en", mem_rd_en, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_win_start", win_start, 0);
    checkOutput("reset_A0", A0_in, 0);
    reset_n = 1'b1;

    applyStimulus(10'h010, 0, -1, 1'b1);
    applyStimulus(10'h020, 7, -1, 1'b0);
    applyStimulus(10'h3FE, 0, -1, 1'b1);

    applyStimulus(10'h100, 0, 1, 1'b0);
    tick();
    tick();
    checkOutput("held_reset_busy", busy, 0);
    reset_n = 1'b1;
    applyStimulus(10'h100, 0, -1, 1'b0);

    for (int n = 0; n < MEM_WORDS; n++) mem[n] = $urandom;
    for (int t = 0; t < 5; t++) begin
      applyStimulus(ADDR_W'($urandom), -1, -1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
